// File: rtl/debounce_pkg.sv
// Shared types and constants for the multi-channel keypad debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHECK_HI  = 2'd1,
    STABLE_HI = 2'd2,
    CHECK_LO  = 2'd3
  } db_state_t;

  localparam int DB_SYNC_STAGES = 2;

endpackage

// File: rtl/debounce_channel.sv
// Single-bit debouncer: optional synchroniser, level-check FSM, counter and event pulses.
// Synchroniser is present when MULTI_DEBOUNCER_SYNC_EN is defined.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic sig_out,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic s;

`ifdef MULTI_DEBOUNCER_SYNC_EN
  logic [DB_SYNC_STAGES-1:0] sync_q;
  logic [DB_SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[DB_SYNC_STAGES-2:0], sig_in};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign s = sync_q[DB_SYNC_STAGES-1];
`else
  assign s = sig_in;
`endif

  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d = CHECK_HI;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      CHECK_HI: begin
        if (!s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          out_d   = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d = CHECK_LO;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      CHECK_LO: begin
        if (s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          out_d   = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign sig_out = out_q;
  assign rise    = rise_q;
  assign fall    = fall_q;

endmodule

// File: rtl/multi_debouncer.sv
// WIDTH independent debounce channels plus any/one-hot summary flags for the keypad scanner.
// Define MULTI_DEBOUNCER_SYNC_EN to add a 2-flop synchroniser in front of each channel.
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sig_in,
  output logic [WIDTH-1:0] sig_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_active,
  output logic             one_hot
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .sig_in (sig_in[i]),
      .sig_out(sig_out[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  always_comb begin
    any_active = |sig_out;
    one_hot    = any_active && ((sig_out & (sig_out - WIDTH'(1))) == '0);
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed self-checking bench for multi_debouncer (WIDTH=4, STABLE_CYCLES=4).
module tb_multi_debouncer;

  localparam int WIDTH = 4;
  localparam int STABLE_CYCLES = 4;
`ifdef MULTI_DEBOUNCER_SYNC_EN
  localparam int D = STABLE_CYCLES + 2;
`else
  localparam int D = STABLE_CYCLES;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] sig_in = '0;
  logic [WIDTH-1:0] sig_out, rise, fall;
  logic             any_active, one_hot;

  int n_chk = 0;
  int n_err = 0;

  multi_debouncer #(
    .WIDTH(WIDTH),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sig_in    (sig_in),
    .sig_out   (sig_out),
    .rise      (rise),
    .fall      (fall),
    .any_active(any_active),
    .one_hot   (one_hot)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".sig_out"}, 32'(sig_out), 32'h0);
    check({tag, ".rise"}, 32'(rise), 32'h0);
    check({tag, ".fall"}, 32'(fall), 32'h0);
    check({tag, ".any"}, 32'(any_active), 32'h0);
    check({tag, ".one_hot"}, 32'(one_hot), 32'h0);
  endtask

  // Drive v, then step D edges; output flips and pulses appear exactly on the D-th edge.
  task automatic run_hold(input string tag, input logic [3:0] v, input logic [3:0] prev_out,
                          input logic [3:0] new_out, input logic [3:0] r_exp,
                          input logic [3:0] f_exp);
    sig_in = v;
    for (int n = 1; n <= D; n++) begin
      step();
      check($sformatf("%s.out%0d", tag, n), 32'(sig_out), 32'(n == D ? new_out : prev_out));
      check($sformatf("%s.rise%0d", tag, n), 32'(rise), 32'(n == D ? r_exp : 4'b0000));
      check($sformatf("%s.fall%0d", tag, n), 32'(fall), 32'(n == D ? f_exp : 4'b0000));
    end
  endtask

  initial begin
    // Reset and idle
    reset = 1'b1;
    #1;
    check_all_zero("rst");
    step();
    step();
    reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      step();
      check_all_zero($sformatf("idle%0d", n));
    end

    // Single channel press
    run_hold("press0", 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    check("press0.any", 32'(any_active), 32'h1);
    check("press0.one_hot", 32'(one_hot), 32'h1);
    step();
    check("press0.rise_gone", 32'(rise), 32'h0);
    check("press0.hold", 32'(sig_out), 32'h1);

    // Three-cycle glitch on channel 1 is rejected
    sig_in = 4'b0011;
    for (int n = 0; n < 3 + D + 2; n++) begin
      if (n == 3) sig_in = 4'b0001;
      step();
      check($sformatf("glitch.out%0d", n), 32'(sig_out), 32'h1);
      check($sformatf("glitch.rise%0d", n), 32'(rise), 32'h0);
      check($sformatf("glitch.fall%0d", n), 32'(fall), 32'h0);
    end

    // Simultaneous fall/rise on different channels
    run_hold("move1", 4'b0010, 4'b0001, 4'b0010, 4'b0010, 4'b0001);
    run_hold("move2", 4'b0100, 4'b0010, 4'b0100, 4'b0100, 4'b0010);
    check("move2.one_hot", 32'(one_hot), 32'h1);
    check("move2.any", 32'(any_active), 32'h1);

    // Two keys: not one-hot
    run_hold("two", 4'b1001, 4'b0100, 4'b1001, 4'b1001, 4'b0100);
    check("two.one_hot", 32'(one_hot), 32'h0);
    check("two.any", 32'(any_active), 32'h1);
    step();
    check("two.pulse_gone", 32'(rise | fall), 32'h0);

    // Reset mid-count clears without a clock edge
    sig_in = 4'b0110;
    step();
    step();
    check("midcnt.out", 32'(sig_out), 32'h9);
    reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    sig_in = 4'b1000;
    step();
    check_all_zero("rst_hold");
    reset = 1'b0;

    // Input already high through reset needs the full count
    run_hold("post_rst", 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b0000);
    check("post_rst.one_hot", 32'(one_hot), 32'h1);

    // Reset during a pulse kills the pulse immediately
    reset = 1'b1;
    #1;
    check_all_zero("pulse_rst");
    step();
    reset = 1'b0;
    sig_in = 4'b0000;
    step();
    check_all_zero("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/multi_debouncer.md
# multi_debouncer

Parametrised multi-channel debouncer for the keypad scanner path. Each of `WIDTH` raw inputs is optionally synchronised, then must hold a new level for `STABLE_CYCLES` consecutive clocks before its debounced output changes. One-cycle press/release pulses and summary flags let the scan FSM react to key events without doing its own edge detection.

## Interface
- `WIDTH`, default 4: number of independent channels (keypad columns); must be ≥ 1.
- `STABLE_CYCLES`, default 50000: consecutive equal samples needed to commit a new level; must be ≥ 2.
- `clk`  input  1: system clock; all state updates on the rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `sig_in`  input  WIDTH: raw, possibly bouncing and asynchronous inputs.
- `sig_out`  output  WIDTH: debounced levels.
- `rise`  output  WIDTH: one-cycle pulse per channel when `sig_out[i]` commits 0→1.
- `fall`  output  WIDTH: one-cycle pulse per channel when `sig_out[i]` commits 1→0.
- `any_active`  output  1: `|sig_out`.
- `one_hot`  output  1: exactly one `sig_out` bit is high.

## Operation
- Channels are fully independent; no cross-channel interaction except the summary flags.
- Per-channel sample `s[i]` is `sig_in[i]` after the optional synchroniser (see Configuration).
- Per-channel FSM, state reset value `STABLE_LO`:
  - `STABLE_LO`: `s=1` → `CHECK_HI`, cnt ← 1; else stay, cnt ← 0.
  - `CHECK_HI`: `s=0` → `STABLE_LO`, cnt ← 0 (bounce rejected). `s=1` and cnt == STABLE_CYCLES−1 → `STABLE_HI`, `sig_out[i]` ← 1, `rise[i]` ← 1, cnt ← 0. Otherwise cnt ← cnt+1.
  - `STABLE_HI`, `CHECK_LO`: mirror images with levels inverted, producing `fall[i]`.
- Counter width is `$clog2(STABLE_CYCLES)`; it never exceeds STABLE_CYCLES−1, so no wrap.
- `rise`/`fall` are registered, high for exactly one cycle, and never both high on the same channel in the same cycle.
- `any_active` and `one_hot` are combinational from registered `sig_out`; no extra latency.
- Multiple channels may commit on the same edge; all their pulses assert together and `one_hot` reflects the resulting vector.

## Timing
- Reset: `sig_out`, `rise`, `fall` = 0; `any_active` = 0; `one_hot` = 0; all FSMs `STABLE_LO`; counters 0; synchroniser flops 0.
- Reset asserted mid-count or mid-pulse clears everything immediately, without waiting for a clock edge. After deassertion, an input already held high needs the full STABLE_CYCLES (plus sync latency) before committing.
- Latency without sync: if `sig_in[i]` is sampled at the new level on edges k … k+STABLE_CYCLES−1, then `sig_out[i]` and the pulse update at edge k+STABLE_CYCLES−1.
- Latency with sync: add 2 cycles.
- Any single opposite-level sample during a check restarts the count from zero.
- A glitch shorter than STABLE_CYCLES produces no output change and no pulse.

## Configuration
- `MULTI_DEBOUNCER_SYNC_EN`:
  - Defined: each `sig_in` bit passes through a 2-flop synchroniser (reset to 0) before the FSM, adding 2 cycles of latency.
  - Undefined: `sig_in` feeds the FSM directly. Only legal when the inputs are already synchronous to `clk`.

## Structure
- Package `debounce_pkg`:
  - typedef enum `db_state_t` {`STABLE_LO`, `CHECK_HI`, `STABLE_HI`, `CHECK_LO`};
  - constant `DB_SYNC_STAGES` = 2.
- Sub-module `debounce_channel`: one bit, holds the sync flops, FSM, counter and pulse regs; parameter `STABLE_CYCLES`.
- Top level: generate loop of `WIDTH` `debounce_channel` instances, plus the summary-flag logic.

## Test plan
Bench uses WIDTH=4, STABLE_CYCLES=4, sync disabled unless stated.
- Reset pulse, then idle inputs → all outputs 0, `one_hot`=0 throughout.
- `sig_in`=0001 held → `sig_out`=0001 at the 4th sampling edge; `rise`=0001 for exactly one cycle; `any_active`=1, `one_hot`=1.
- `sig_in[1]` high for 3 cycles, then low → `sig_out` unchanged, no `rise`.
- Hold 0010, then change to 0100 → `fall`=0010 and `rise`=0100 on the same edge; `sig_out`=0100.
- Hold 1001 → `sig_out`=1001, `one_hot`=0, `any_active`=1. Assert `reset` mid-count on a second change → outputs 0 immediately, without a clock edge.
- With `MULTI_DEBOUNCER_SYNC_EN` defined, repeat the second scenario → commit occurs 2 cycles later.
